panel_switch_conditioner: RTL and testbench

//  Conditions raw active-low front-panel switches before they reach the PDP8e core.

---
 rtl/panel_switch_conditioner_pkg.sv | 50 +++++
 rtl/panel_switch_conditioner_debounce.sv | 121 ++++++++++++
 rtl/panel_switch_conditioner.sv | 168 ++++++++++++++++
 tb/tb_panel_switch_conditioner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_switch_conditioner_pkg.sv
// Shared definitions for the front-panel switch conditioner.
// Holds the debouncer state encoding, the switch index map, the run-interlock
// mask and the pulse priority order, plus the priority-grant helper.
package panel_switch_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_LOCKOUT      = 3'd0,
    ST_IDLE         = 3'd1,
    ST_PRESS_WAIT   = 3'd2,
    ST_HELD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } deb_state_t;

  localparam int unsigned NUM_KEYS = 6;  // momentary keys, indices 0..5
  localparam int unsigned NUM_SW   = 8;  // keys plus the two level switches

  localparam int unsigned SW_ADDR_LOAD = 0;
  localparam int unsigned SW_DEP       = 1;
  localparam int unsigned SW_EXAM      = 2;
  localparam int unsigned SW_CONT      = 3;
  localparam int unsigned SW_EXTD_ADDR = 4;
  localparam int unsigned SW_CLEAR     = 5;
  localparam int unsigned SW_HALT      = 6;
  localparam int unsigned SW_SING_STEP = 7;

  // Keys blocked while the processor runs; CONT is the only one left live.
  localparam logic [NUM_KEYS-1:0] INTERLOCK_MASK = 6'b110111;

  // Highest priority first.
  localparam logic [2:0] PRIO_ORDER [NUM_KEYS] = '{
    3'(SW_CLEAR), 3'(SW_CONT), 3'(SW_ADDR_LOAD),
    3'(SW_EXTD_ADDR), 3'(SW_DEP), 3'(SW_EXAM)
  };

  // One-hot grant of the highest-priority request; lower requests are dropped.
  function automatic logic [NUM_KEYS-1:0] prio_grant(input logic [NUM_KEYS-1:0] req);
    logic [NUM_KEYS-1:0] grant;
    logic                taken;
    grant = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!taken && req[PRIO_ORDER[i]]) begin
        grant[PRIO_ORDER[i]] = 1'b1;
        taken                = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/panel_switch_conditioner_debounce.sv
// Single-switch conditioner: 2-flop synchroniser followed by a debounce FSM.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   raw_n       raw active-low switch pin (0 = pressed)
//   level       1 while debounced pressed (HELD or RELEASE_WAIT)
//   rise        one-clk pulse in the cycle after the FSM enters HELD
//   held        1 while the FSM is in HELD
//   lockout     1 while the FSM is in LOCKOUT (from reset until a stable release)
module panel_switch_conditioner_debounce
  import panel_switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise,
  output logic held,
  output logic lockout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  deb_state_t    state;
  logic [CW-1:0] count;

  assign pressed = ~sync2;

  // Synchroniser resets to "pressed" so LOCKOUT only ever sees genuine releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
    end
  end

  // Debounce FSM; count tracks consecutive stable samples and stops at FULL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_LOCKOUT;
      count   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      held    <= 1'b0;
      lockout <= 1'b1;
    end else begin
      rise <= 1'b0;
      case (state)
        ST_LOCKOUT: begin
          if (pressed) begin
            count <= '0;
          end else if (count >= LAST) begin
            state   <= ST_IDLE;
            count   <= '0;
            lockout <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        ST_IDLE: begin
          if (pressed) begin
            state <= ST_PRESS_WAIT;
            count <= CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (count >= LAST) begin
            state <= ST_HELD;
            count <= FULL;
            level <= 1'b1;
            held  <= 1'b1;
            rise  <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            state <= ST_RELEASE_WAIT;
            count <= CW'(1);
            held  <= 1'b0;
          end
        end
        ST_RELEASE_WAIT: begin
          // A bounce back to pressed resumes the same press; no new rise.
          if (pressed) begin
            state <= ST_HELD;
            count <= FULL;
            held  <= 1'b1;
          end else if (count >= LAST) begin
            state <= ST_IDLE;
            count <= '0;
            level <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state   <= ST_LOCKOUT;
          count   <= '0;
          level   <= 1'b0;
          held    <= 1'b0;
          lockout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner for the PDP8e core.
// Debounces the six momentary keys into single-clk pulses (with run interlock
// and fixed priority), debounces HALT / SING STEP into levels and
// double-flop synchronises the switch register and display select.
// Optional feature macro: PANEL_REPEAT_EN enables DEP/EXAM auto-repeat.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   addr_loadn..clearn                 raw momentary keys, 0 = pressed
//   haltn, single_stepn                raw level switches, 0 = on
//   sr_in[0:11], dsel_in[0:5]          raw switch register / display select
//   run                                core run flag
//   addr_load_p..clear_p               one-clk press pulses
//   halt, single_step                  debounced levels, 1 = on
//   sr[0:11], dsel[0:5]                synchronised sr_in / dsel_in
module panel_switch_conditioner
  import panel_switch_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_loadn,
  input  logic        depn,
  input  logic        examn,
  input  logic        contn,
  input  logic        extd_addrn,
  input  logic        clearn,
  input  logic        haltn,
  input  logic        single_stepn,
  input  logic [0:11] sr_in,
  input  logic [0:5]  dsel_in,
  input  logic        run,
  output logic        addr_load_p,
  output logic        dep_p,
  output logic        exam_p,
  output logic        cont_p,
  output logic        extd_addr_p,
  output logic        clear_p,
  output logic        halt,
  output logic        single_step,
  output logic [0:11] sr,
  output logic [0:5]  dsel
);

  logic [NUM_SW-1:0]   raw_n;
  logic [NUM_SW-1:0]   lvl;
  logic [NUM_SW-1:0]   rise;
  logic [NUM_SW-1:0]   held;
  logic [NUM_SW-1:0]   lockout;
  logic [NUM_KEYS-1:0] rpt_c;
  logic [NUM_KEYS-1:0] req_c;
  logic [NUM_KEYS-1:0] grant_c;
  logic [NUM_KEYS-1:0] pulse_q;
  logic [0:11]         sr_meta;
  logic [0:5]          dsel_meta;

  assign raw_n[SW_ADDR_LOAD] = addr_loadn;
  assign raw_n[SW_DEP]       = depn;
  assign raw_n[SW_EXAM]      = examn;
  assign raw_n[SW_CONT]      = contn;
  assign raw_n[SW_EXTD_ADDR] = extd_addrn;
  assign raw_n[SW_CLEAR]     = clearn;
  assign raw_n[SW_HALT]      = haltn;
  assign raw_n[SW_SING_STEP] = single_stepn;

  // One debouncer per switch.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    panel_switch_conditioner_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_n  (raw_n[i]),
      .level  (lvl[i]),
      .rise   (rise[i]),
      .held   (held[i]),
      .lockout(lockout[i])
    );
  end

`ifdef PANEL_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic [1:0] rpt2_c;

  // Auto-repeat timers for DEP (j=0) and EXAM (j=1); frozen in RELEASE_WAIT.
  for (genvar j = 0; j < 2; j++) begin : g_rpt
    localparam int unsigned KEY = (j == 0) ? SW_DEP : SW_EXAM;

    logic [RW-1:0] cnt;
    logic          first;
    logic [RW-1:0] target_c;

    assign target_c  = first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    assign rpt2_c[j] = held[KEY] && (cnt == target_c);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        first <= 1'b1;
      end else if (!lvl[KEY]) begin
        cnt   <= '0;
        first <= 1'b1;
      end else if (held[KEY]) begin
        if (rpt2_c[j]) begin
          cnt   <= RW'(1);
          first <= 1'b0;
        end else begin
          cnt <= cnt + RW'(1);
        end
      end
    end
  end

  always_comb begin
    rpt_c          = '0;
    rpt_c[SW_DEP]  = rpt2_c[0];
    rpt_c[SW_EXAM] = rpt2_c[1];
  end
`else
  assign rpt_c = '0;

  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Interlock first, then priority: a suppressed key never blocks a live one.
  always_comb begin
    req_c   = (rise[NUM_KEYS-1:0] | rpt_c) & ~(run ? INTERLOCK_MASK : '0);
    grant_c = prio_grant(req_c);
  end

  // Registered outputs; halt stays forced on until its debouncer leaves LOCKOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q     <= '0;
      halt        <= 1'b1;
      single_step <= 1'b0;
      sr_meta     <= '0;
      sr          <= '0;
      dsel_meta   <= '0;
      dsel        <= '0;
    end else begin
      pulse_q     <= grant_c;
      halt        <= lvl[SW_HALT] | lockout[SW_HALT];
      single_step <= lvl[SW_SING_STEP];
      sr_meta     <= sr_in;
      sr          <= sr_meta;
      dsel_meta   <= dsel_in;
      dsel        <= dsel_meta;
    end
  end

  assign addr_load_p = pulse_q[SW_ADDR_LOAD];
  assign dep_p       = pulse_q[SW_DEP];
  assign exam_p      = pulse_q[SW_EXAM];
  assign cont_p      = pulse_q[SW_CONT];
  assign extd_addr_p = pulse_q[SW_EXTD_ADDR];
  assign clear_p     = pulse_q[SW_CLEAR];

  logic unused_sigs;
  assign unused_sigs = ^{lvl[NUM_KEYS-1:0], rise[NUM_SW-1:NUM_KEYS], held,
                         lockout[SW_SING_STEP], lockout[NUM_KEYS-1:0]};

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Self-checking bench for panel_switch_conditioner (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8). Expected pulses are queued with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_panel_switch_conditioner;

  localparam logic [5:0] P_ADDR  = 6'b000001;
  localparam logic [5:0] P_DEP   = 6'b000010;
  localparam logic [5:0] P_EXAM  = 6'b000100;
  localparam logic [5:0] P_CONT  = 6'b001000;
  localparam logic [5:0] P_EXTD  = 6'b010000;
  localparam logic [5:0] P_CLEAR = 6'b100000;
  localparam int unsigned LAT    = 7;  // 2 sync + 4 debounce + 1 output

  typedef struct packed {
    logic [5:0]  vec;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        addr_loadn, depn, examn, contn, extd_addrn, clearn;
  logic        haltn, single_stepn;
  logic [0:11] sr_in;
  logic [0:5]  dsel_in;
  logic        run;
  logic        addr_load_p, dep_p, exam_p, cont_p, extd_addr_p, clear_p;
  logic        halt, single_step;
  logic [0:11] sr;
  logic [0:5]  dsel;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned c;

  panel_switch_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr_loadn  (addr_loadn),
    .depn        (depn),
    .examn       (examn),
    .contn       (contn),
    .extd_addrn  (extd_addrn),
    .clearn      (clearn),
    .haltn       (haltn),
    .single_stepn(single_stepn),
    .sr_in       (sr_in),
    .dsel_in     (dsel_in),
    .run         (run),
    .addr_load_p (addr_load_p),
    .dep_p       (dep_p),
    .exam_p      (exam_p),
    .cont_p      (cont_p),
    .extd_addr_p (extd_addr_p),
    .clear_p     (clear_p),
    .halt        (halt),
    .single_step (single_step),
    .sr          (sr),
    .dsel        (dsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [5:0] v, input int unsigned at);
    exp_q.push_back('{vec: v, cyc: at});
  endtask

  function automatic logic [5:0] pulses();
    return {clear_p, extd_addr_p, cont_p, exam_p, dep_p, addr_load_p};
  endfunction

  // Scoreboard monitor: every non-zero pulse cycle must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (pulses() != 6'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(pulses()), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_vec", 64'(pulses()), 64'(e.vec));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1;
    {addr_loadn, depn, contn, extd_addrn, clearn} = 5'b11111;
    examn = 1'b0;               // held through reset release
    haltn = 1'b1;
    single_stepn = 1'b1;
    sr_in = '0;
    dsel_in = '0;
    run = 1'b0;

    // Reset state
    wait_clk(2);
    check("rst_halt", 64'(halt), 64'd1);
    check("rst_single_step", 64'(single_step), 64'd0);
    check("rst_sr", 64'(sr), 64'd0);
    check("rst_dsel", 64'(dsel), 64'd0);
    check("rst_pulses", 64'(pulses()), 64'd0);
    reset = 1'b0;
    wait_clk(2);
    check("halt_lockout", 64'(halt), 64'd1);
    wait_clk(8);
    check("halt_after_lockout", 64'(halt), 64'd0);

    // Key held through reset never pulses; a later press does
    wait_clk(10);
    examn = 1'b1;
    wait_clk(10);
    c = cyc; examn = 1'b0; expect_pulse(P_EXAM, c + LAT);
    wait_clk(12);
    examn = 1'b1;
    wait_clk(15);
    check("q_empty_exam", 64'(exp_q.size()), 64'd0);

    // CONT: one pulse, LAT cycles after the fall, nothing on release
    c = cyc; contn = 1'b0; expect_pulse(P_CONT, c + LAT);
    wait_clk(30);
    contn = 1'b1;
    wait_clk(15);
    check("q_empty_cont", 64'(exp_q.size()), 64'd0);

    // DEP glitch shorter than the debounce window
    depn = 1'b0;
    wait_clk(3);
    depn = 1'b1;
    wait_clk(15);
    check("q_empty_glitch", 64'(exp_q.size()), 64'd0);

    // Run interlock: interlocked keys suppressed, CONT still fires
    run = 1'b1;
    addr_loadn = 1'b0; extd_addrn = 1'b0; clearn = 1'b0;
    wait_clk(10);
    addr_loadn = 1'b1; extd_addrn = 1'b1; clearn = 1'b1;
    wait_clk(15);
    c = cyc; contn = 1'b0; expect_pulse(P_CONT, c + LAT);
    wait_clk(10);
    contn = 1'b1;
    wait_clk(15);
    addr_loadn = 1'b0;          // reaches HELD under run, run then drops
    wait_clk(12);
    run = 1'b0;
    wait_clk(5);
    addr_loadn = 1'b1;
    wait_clk(15);
    check("q_empty_interlock", 64'(exp_q.size()), 64'd0);
    c = cyc; addr_loadn = 1'b0; expect_pulse(P_ADDR, c + LAT);
    wait_clk(10);
    addr_loadn = 1'b1;
    wait_clk(15);
    c = cyc; extd_addrn = 1'b0; expect_pulse(P_EXTD, c + LAT);
    wait_clk(10);
    extd_addrn = 1'b1;
    wait_clk(15);
    check("q_empty_run0", 64'(exp_q.size()), 64'd0);

    // Simultaneous CLEAR and DEP: CLEAR wins, DEP dropped
    c = cyc; clearn = 1'b0; depn = 1'b0; expect_pulse(P_CLEAR, c + LAT);
    wait_clk(12);
    clearn = 1'b1; depn = 1'b1;
    wait_clk(15);
    check("q_empty_prio", 64'(exp_q.size()), 64'd0);

    // DEP held 60 clk (auto-repeat when enabled)
    c = cyc; depn = 1'b0; expect_pulse(P_DEP, c + LAT);
`ifdef PANEL_REPEAT_EN
    expect_pulse(P_DEP, c + 27);
    expect_pulse(P_DEP, c + 35);
    expect_pulse(P_DEP, c + 43);
    expect_pulse(P_DEP, c + 51);
    expect_pulse(P_DEP, c + 59);
`endif
    wait_clk(60);
    depn = 1'b1;
    wait_clk(20);
    check("q_empty_dep_hold", 64'(exp_q.size()), 64'd0);

    // Level switches
    haltn = 1'b0; single_stepn = 1'b0;
    wait_clk(6);
    check("halt_before_lat", 64'(halt), 64'd0);
    check("ss_before_lat", 64'(single_step), 64'd0);
    wait_clk(1);
    check("halt_on", 64'(halt), 64'd1);
    check("ss_on", 64'(single_step), 64'd1);
    haltn = 1'b1; single_stepn = 1'b1;
    wait_clk(15);
    check("halt_off", 64'(halt), 64'd0);
    check("ss_off", 64'(single_step), 64'd0);

    // SR / DSEL two-flop sync
    sr_in = 12'hA5C; dsel_in = 6'h2B;
    wait_clk(1);
    check("sr_one_clk", 64'(sr), 64'd0);
    wait_clk(1);
    check("sr_sync", 64'(sr), 64'hA5C);
    check("dsel_sync", 64'(dsel), 64'h2B);

    // Reset mid-debounce aborts the press
    contn = 1'b0;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(1);
    check("halt_in_reset", 64'(halt), 64'd1);
    wait_clk(1);
    reset = 1'b0;
    wait_clk(20);
    contn = 1'b1;
    wait_clk(15);
    check("q_empty_reset_abort", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
